// File: rtl/pulse_train_gen.sv
// pulse_train_gen: registered N-pulse waveform generator.
// Each pulse is H cycles high then L cycles low; a done strobe follows the train.
module pulse_train_gen #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [LEN_W-1:0] i_high_len,
    input  logic [LEN_W-1:0] i_low_len,
    input  logic [CNT_W-1:0] i_num,
    output logic             o_wave,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] phase_cnt, phase_nx;
    logic [CNT_W-1:0] pulse_cnt, pulse_nx;
    logic [LEN_W-1:0] h_len, h_nx;
    logic [LEN_W-1:0] l_len, l_nx;
    logic [CNT_W-1:0] n_num, n_nx;
    logic             wave, wave_nx;
    logic             busy, busy_nx;
    logic             done, done_nx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            pulse_cnt <= '0;
            h_len     <= '0;
            l_len     <= '0;
            n_num     <= '0;
            wave      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            phase_cnt <= phase_nx;
            pulse_cnt <= pulse_nx;
            h_len     <= h_nx;
            l_len     <= l_nx;
            n_num     <= n_nx;
            wave      <= wave_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase_cnt;
        pulse_nx = pulse_cnt;
        h_nx     = h_len;
        l_nx     = l_len;
        n_nx     = n_num;
        wave_nx  = wave;
        busy_nx  = busy;
        done_nx  = 1'b0;
        unique case (state)
            S_IDLE: begin
                // abort outranks start, so a simultaneous pair does nothing
                if (i_start && !i_abort) begin
                    h_nx     = (i_high_len == '0) ? LEN_W'(1) : i_high_len;
                    l_nx     = (i_low_len == '0) ? LEN_W'(1) : i_low_len;
                    n_nx     = i_num;
                    phase_nx = LEN_W'(1);
                    pulse_nx = '0;
                    if (i_num == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = S_HIGH;
                        wave_nx  = 1'b1;
                        busy_nx  = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (i_abort) begin
                    state_nx = S_IDLE;
                    phase_nx = '0;
                    pulse_nx = '0;
                    wave_nx  = 1'b0;
                    busy_nx  = 1'b0;
                end else if (phase_cnt == h_len) begin
                    state_nx = S_LOW;
                    phase_nx = LEN_W'(1);
                    pulse_nx = pulse_cnt + CNT_W'(1);
                    wave_nx  = 1'b0;
                end else begin
                    phase_nx = phase_cnt + LEN_W'(1);
                end
            end
            S_LOW: begin
                if (i_abort) begin
                    state_nx = S_IDLE;
                    phase_nx = '0;
                    pulse_nx = '0;
                    wave_nx  = 1'b0;
                    busy_nx  = 1'b0;
                end else if (phase_cnt == l_len) begin
                    if (pulse_cnt == n_num) begin
                        state_nx = S_IDLE;
                        phase_nx = '0;
                        pulse_nx = '0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = S_HIGH;
                        phase_nx = LEN_W'(1);
                        wave_nx  = 1'b1;
                    end
                end else begin
                    phase_nx = phase_cnt + LEN_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                wave_nx  = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign o_wave = wave;
    assign o_busy = busy;
    assign o_done = done;

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Source-side counterpart of the rising-edge detector: generates a registered, glitch-free level waveform whose rising edges the detector turns back into single-cycle pulses.
- On a one-cycle start request it emits N pulses, each high for H cycles and low for L cycles, then signals completion.
- Used as the stimulus/strobe generator in front of edge-detecting consumers, and for loopback checking against the detector.

Parameters:
- LEN_W, 8, width of high/low phase length inputs and phase counter.
- CNT_W, 8, width of pulse-count input and pulse counter.

Ports:
- i_clk  input  1  system clock, all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_abort  input  1  synchronous abort of a running train.
- i_high_len  input  LEN_W  high-phase length in cycles (0 treated as 1).
- i_low_len  input  LEN_W  low-phase length in cycles (0 treated as 1).
- i_num  input  CNT_W  number of pulses in the train.
- o_wave  output  1  generated waveform, driven directly from a flop.
- o_busy  output  1  high while a train is in progress.
- o_done  output  1  one-cycle completion strobe.

Behaviour:
- Reset: asynchronous, active-high. o_wave=0, o_busy=0, o_done=0, state=IDLE, all counters 0. Outputs go to these values immediately on i_rst, including mid-train. No done strobe is issued for a train killed by reset.
- States: IDLE, HIGH, LOW.
- IDLE, i_start=1 at an edge:
  - Latch H=max(i_high_len,1), L=max(i_low_len,1), N=i_num.
  - If N=0: stay IDLE, o_done=1 for the next cycle only, o_wave stays 0, o_busy stays 0.
  - Else: go to HIGH. From the next cycle, o_wave=1 and o_busy=1.
- HIGH: o_wave=1 for exactly H cycles, then go to LOW.
- LOW: o_wave=0 for exactly L cycles, then:
  - If pulses emitted < N: go to HIGH.
  - Else: go to IDLE.
- Completion: in the first cycle after the final LOW phase, o_busy=0 and o_done=1 for exactly one cycle.
- Latency: first o_wave rise is 1 cycle after the start edge.
- Total busy time is N*(H+L) cycles. o_wave shows exactly N rising edges per train.
- Latched H, L and N are immutable during a train. Input changes while busy are ignored.
- i_start while busy: ignored and not queued.
- i_start in the same cycle o_done=1: accepted, because state is IDLE. The new train's o_wave rises on the next cycle, giving back-to-back trains.
- i_abort while busy: at the next edge, state=IDLE, o_wave=0, o_busy=0, o_done stays 0.
- i_abort in IDLE: no effect. Simultaneous i_start and i_abort in IDLE: abort wins and the start is dropped.
- Counters:
  - Phase counter counts 1..H (or 1..L) and reloads on each phase change.
  - Pulse counter increments at each HIGH→LOW transition.
  - Comparisons are exact-width with no wrap. Maximum lengths are 2^LEN_W−1, and N up to 2^CNT_W−1 are supported.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert i_rst mid-HIGH of a train (H=5, L=5, N=3) -> o_wave, o_busy, o_done read 0 within #1 of assertion. After release, the block is in IDLE and a new start works.
- Basic train: H=2, L=3, N=4, start one cycle -> o_wave rises 1 cycle after the start edge; pattern 11000 repeated 4 times; o_busy high for 20 cycles; o_done single pulse in cycle 21; exactly 4 rising edges counted on o_wave.
- Boundaries:
  - H=0, L=0, N=1 -> behaves as H=1, L=1: o_wave high for 1 cycle, low for 1 cycle, o_done in cycle 3.
  - N=0 -> o_done high for 1 cycle after the start edge, o_wave never rises, o_busy never asserts.
- Ignored/back-to-back start: i_start pulsed again during a busy H=3, L=3, N=2 train -> no effect, total busy 12 cycles. i_start asserted in the o_done cycle -> new train's o_wave rises on the next edge.
- Abort: i_abort during the 2nd LOW phase of N=5 -> next edge o_wave=0, o_busy=0, no o_done. Simultaneous start+abort in IDLE -> nothing starts.
- Loopback: o_wave feeds the rising-edge detector with H=1, L=1, N=8 -> detector output pulses exactly 8 times, each one cycle wide, at the rising edge after each o_wave rise. Detector output stays 0 at negative clock edges.
